// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, 2-bit IR, bypass register
// and TDO mux, driving the select/enable/update controls of a boundary-cell chain.
module tap_controller #(
  parameter int              IR_W   = 2,
  parameter logic [IR_W-1:0] EXTEST = 2'b00,
  parameter logic [IR_W-1:0] SAMPLE = 2'b01,
  parameter logic [IR_W-1:0] BYPASS = 2'b11
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            BSR_TDO,
  output logic            Shift_or_Load,
  output logic            BSR_Clock_en,
  output logic            Update,
  output logic            Test_or_Normal,
  output logic            TDO,
  output logic            TDO_en,
  output logic [3:0]      state,
  output logic [IR_W-1:0] ir
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC,
    SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
    PAUDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
    SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
    PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
  } tap_state_e;

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_shift_q, ir_shift_d;
  logic            bypass_q, bypass_d;
  logic            ton_q, ton_d;
  logic            bsr_sel;

  assign bsr_sel = (ir_q == EXTEST) || (ir_q == SAMPLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= TLR;
      ir_q       <= BYPASS;
      ir_shift_q <= 2'b01;
      bypass_q   <= 1'b0;
      ton_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
      ton_q      <= ton_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:   state_d = TMS ? TLR   : RTI;
      RTI:   state_d = TMS ? SELDR : RTI;
      SELDR: state_d = TMS ? SELIR : CAPDR;
      CAPDR: state_d = TMS ? EX1DR : SHDR;
      SHDR:  state_d = TMS ? EX1DR : SHDR;
      EX1DR: state_d = TMS ? UPDDR : PAUDR;
      PAUDR: state_d = TMS ? EX2DR : PAUDR;
      EX2DR: state_d = TMS ? UPDDR : SHDR;
      UPDDR: state_d = TMS ? SELDR : RTI;
      SELIR: state_d = TMS ? TLR   : CAPIR;
      CAPIR: state_d = TMS ? EX1IR : SHIR;
      SHIR:  state_d = TMS ? EX1IR : SHIR;
      EX1IR: state_d = TMS ? UPDIR : PAUIR;
      PAUIR: state_d = TMS ? EX2IR : PAUIR;
      EX2IR: state_d = TMS ? UPDIR : SHIR;
      UPDIR: state_d = TMS ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Data-path registers; pause states fall through to hold.
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    ton_d      = (state_q == TLR) ? 1'b0 : (ir_q == EXTEST);
    case (state_q)
      TLR:   ir_d       = BYPASS;
      CAPIR: ir_shift_d = 2'b01;
      SHIR:  ir_shift_d = {TDI, ir_shift_q[IR_W-1:1]};
      UPDIR: ir_d       = ir_shift_q;
      CAPDR: if (!bsr_sel) bypass_d = 1'b0;
      SHDR:  if (!bsr_sel) bypass_d = TDI;
      default: ;
    endcase
  end

  always_comb begin
    TDO = 1'b0;
    if (state_q == SHIR)      TDO = ir_shift_q[0];
    else if (state_q == SHDR) TDO = bsr_sel ? BSR_TDO : bypass_q;
  end

  assign Shift_or_Load  = (state_q == SHDR) && bsr_sel;
  assign BSR_Clock_en   = ((state_q == CAPDR) || (state_q == SHDR)) && bsr_sel;
  assign Update         = (state_q == UPDDR) && bsr_sel;
  assign Test_or_Normal = ton_q;
  assign TDO_en         = (state_q == SHDR) || (state_q == SHIR);
  assign state          = state_q;
  assign ir             = ir_q;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: per-cycle vector table of TMS/TDI/BSR_TDO with
// hand-computed state and outputs, plus hand sequences for reset and short DR paths.
module tb_tap_controller;
  logic       Clock = 1'b0;
  logic       Reset, TMS, TDI, BSR_TDO;
  logic       Shift_or_Load, BSR_Clock_en, Update, Test_or_Normal, TDO, TDO_en;
  logic [3:0] state;
  logic [1:0] ir;

  int checks = 0;
  int failures = 0;

  tap_controller dut (
    .Clock(Clock), .Reset(Reset), .TMS(TMS), .TDI(TDI), .BSR_TDO(BSR_TDO),
    .Shift_or_Load(Shift_or_Load), .BSR_Clock_en(BSR_Clock_en), .Update(Update),
    .Test_or_Normal(Test_or_Normal), .TDO(TDO), .TDO_en(TDO_en),
    .state(state), .ir(ir)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       tms, tdi, btdo;
    logic [3:0] st;
    logic [1:0] ir;
    logic       sol, bce, upd, ton, tdo, tden;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic tms, tdi, btdo, input logic [3:0] st,
                              input logic [1:0] irv, input logic sol, bce, upd, ton, tdo, tden);
    vec_t v;
    v = '{tms, tdi, btdo, st, irv, sol, bce, upd, ton, tdo, tden};
    return v;
  endfunction

  // observed bundle: {state, ir, sol, bce, upd, ton, tdo, tden}
  function automatic logic [11:0] obs();
    return {state, ir, Shift_or_Load, BSR_Clock_en, Update, Test_or_Normal, TDO, TDO_en};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, tms, tdi);
    @(negedge Clock);
    Reset = rst; TMS = tms; TDI = tdi;
    @(posedge Clock);
    #1;
  endtask

  logic upd_seen;

  initial begin
    Reset = 1'b1; TMS = 1'b1; TDI = 1'b0; BSR_TDO = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_state", obs(), {4'hF, 2'b11, 6'b0});

    // args: tms tdi btdo | state ir sol bce upd ton tdo tden
    tbl.push_back(mk(0,0,0,4'hF,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'hC,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'h7,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'h6,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h2,2'b11,0,0,0,0,0,1)); // ShDR, then five TMS=1
    tbl.push_back(mk(1,0,0,4'h1,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h5,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h7,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h4,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'hF,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hF,2'b11,0,0,0,0,0,0));
    // load EXTEST
    tbl.push_back(mk(1,0,0,4'hC,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'h7,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'h4,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hE,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hA,2'b11,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,4'hA,2'b11,0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,4'h9,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hD,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hC,2'b00,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4'hC,2'b00,0,0,0,1,0,0));
    // EXTEST DR scan, 4 cells, with a pause
    tbl.push_back(mk(0,0,0,4'h7,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,4'h6,2'b00,0,1,0,1,0,0));
    tbl.push_back(mk(0,0,1,4'h2,2'b00,1,1,0,1,1,1));
    tbl.push_back(mk(0,0,0,4'h2,2'b00,1,1,0,1,0,1));
    tbl.push_back(mk(0,0,1,4'h2,2'b00,1,1,0,1,1,1));
    tbl.push_back(mk(1,0,1,4'h2,2'b00,1,1,0,1,1,1));
    tbl.push_back(mk(0,0,0,4'h1,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,4'h3,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,4'h0,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,4'h5,2'b00,0,0,1,1,0,0));
    tbl.push_back(mk(1,0,0,4'hC,2'b00,0,0,0,1,0,0));
    // load BYPASS (shift in 1,1)
    tbl.push_back(mk(1,0,0,4'h7,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,4'h4,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,4'hE,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,4'hA,2'b00,0,0,0,1,1,1));
    tbl.push_back(mk(1,1,0,4'hA,2'b00,0,0,0,1,0,1));
    tbl.push_back(mk(1,0,0,4'h9,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,4'hD,2'b00,0,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,4'hC,2'b11,0,0,0,1,0,0));
    // bypass scan 1,0,1,1 -> TDO 0,1,0,1; BSR_TDO held high must not leak
    tbl.push_back(mk(0,0,0,4'h7,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'h6,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,4'h2,2'b11,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,4'h2,2'b11,0,0,0,0,1,1));
    tbl.push_back(mk(0,1,1,4'h2,2'b11,0,0,0,0,0,1));
    tbl.push_back(mk(1,1,1,4'h2,2'b11,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,4'h1,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'h5,2'b11,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hC,2'b11,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge Clock);
      Reset = 1'b0; TMS = tbl[i].tms; TDI = tbl[i].tdi; BSR_TDO = tbl[i].btdo;
      #1;
      chk($sformatf("vec%0d", i), obs(),
          {tbl[i].st, tbl[i].ir, tbl[i].sol, tbl[i].bce, tbl[i].upd,
           tbl[i].ton, tbl[i].tdo, tbl[i].tden});
    end
    // last vector's edge lands in RTI
    BSR_TDO = 1'b0;

    // CapDR -> Ex1DR -> UpdDR with BYPASS active: no Update pulse
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("upd_direct_bypass", obs(), {4'h5, 2'b11, 6'b0});
    cyc(0, 0, 0);
    chk("back_to_rti", obs(), {4'hC, 2'b11, 6'b0});

    // Reset in the middle of ShIR after shifting 00
    upd_seen = 1'b0;
    cyc(0, 1, 0); upd_seen |= Update;
    cyc(0, 1, 0); upd_seen |= Update;
    cyc(0, 0, 0); upd_seen |= Update;
    cyc(0, 0, 0); upd_seen |= Update;
    chk("in_shir", obs(), {4'hA, 2'b11, 4'b0, 1'b1, 1'b1});
    cyc(0, 0, 0); upd_seen |= Update;
    cyc(0, 0, 0); upd_seen |= Update;
    chk("shir_shifted", obs(), {4'hA, 2'b11, 4'b0, 1'b0, 1'b1});
    cyc(1, 1, 0); upd_seen |= Update;
    chk("reset_mid_shir", obs(), {4'hF, 2'b11, 6'b0});
    cyc(0, 0, 0); upd_seen |= Update;
    chk("after_reset_rti", obs(), {4'hC, 2'b11, 6'b0});
    chk("no_update_pulse", {11'b0, upd_seen}, 12'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tap_controller.md
# tap_controller

Single-clock IEEE 1149.1-style TAP controller that sequences a chain of boundary cells. It tracks the 16-state TAP FSM from TMS, holds a 2-bit instruction register, and drives the chain's shift/load select, capture/shift enable, update pulse and test/normal select. It also owns the 1-bit bypass register and the serial TDO multiplexer. It sits between the scan port pins and the boundary-cell chain, whose serial output returns on `BSR_TDO`.

## Interface
- `IR_W`, default 2: instruction register width (fixed at 2 in this revision).
- `EXTEST`, default 2'b00: drive boundary-cell outputs from the update stage.
- `SAMPLE`, default 2'b01: SAMPLE/PRELOAD; boundary register selected, system path stays normal.
- `BYPASS`, default 2'b11: bypass register selected. Code 2'b10 decodes as BYPASS.
- `Clock  in  1`: TCK-equivalent; all state changes on its rising edge.
- `Reset  in  1`: synchronous, active-high; forces Test-Logic-Reset.
- `TMS  in  1`: mode select, sampled every Clock edge.
- `TDI  in  1`: serial data in; routed to chain, IR and bypass.
- `BSR_TDO  in  1`: serial out of the last boundary cell.
- `Shift_or_Load  out  1`: 1 selects TDI into the cells, 0 selects Systemdata.
- `BSR_Clock_en  out  1`: enable for the cells' capture/shift flop.
- `Update  out  1`: one-cycle update enable for the cells' output flop.
- `Test_or_Normal  out  1`: 1 while EXTEST is the active instruction.
- `TDO  out  1`: serial out.
- `TDO_en  out  1`: high in Shift-DR and Shift-IR only.
- `state  out  4`: current TAP state, debug.
- `ir  out  IR_W`: active instruction.

## Operation
- **State encoding:**
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- **Transitions** (TMS=0 / TMS=1):
  - TLR→RTI/TLR; RTI→RTI/SelDR
  - SelDR→CapDR/SelIR; SelIR→CapIR/TLR
  - Cap→Sh/Ex1; Sh→Sh/Ex1; Ex1→Pau/Upd
  - Pau→Pau/Ex2; Ex2→Sh/Upd; Upd→RTI/SelDR
  - The Cap/Sh/Ex1/Pau/Ex2/Upd rules apply identically to the DR and IR branches.
- **Instruction register:**
  - `ir_shift`: CapIR loads 2'b01. Each ShIR cycle shifts right, with TDI entering the MSB.
  - `ir`: UpdIR copies `ir_shift` into `ir`. In TLR, `ir` is BYPASS.
- **bsr_sel:** true when `ir` is EXTEST or SAMPLE.
- **Bypass register:** CapDR loads 0. ShDR loads TDI. Only active when `bsr_sel` is false.
- **Outputs decoded combinationally from `state` (Moore):**
  - `Shift_or_Load` = (state==ShDR) & bsr_sel
  - `BSR_Clock_en` = (state∈{CapDR,ShDR}) & bsr_sel
  - `Update` = (state==UpdDR) & bsr_sel
- **Test_or_Normal:** registered. Set to (`ir`==EXTEST) on the edge after `ir` changes. Cleared in TLR.
- **TDO mux:**
  - ShIR: `ir_shift[0]`
  - ShDR with bsr_sel: `BSR_TDO`
  - ShDR without bsr_sel: bypass bit
  - Otherwise: 0

## Timing
- **Reset values:** `state`=F, `ir`=2'b11, `ir_shift`=2'b01, bypass=0, `Test_or_Normal`=0. All decoded outputs are 0 and `TDO_en`=0.
- **Reset priority:** Reset mid-operation wins on that edge. There is no update of `ir` and no `Update` pulse.
- **TMS-high recovery:** five consecutive TMS=1 edges reach TLR from any state.
- **Capture timing:** the chain captures Systemdata on the edge leaving CapDR. Each ShDR edge shifts one bit.
- **Update timing:** `Update` is high for exactly the one cycle spent in UpdDR. There is no pulse if UpdDR is reached via Ex1DR directly from CapDR and `bsr_sel` is false.
- **Pause:** PauDR/PauIR hold all shift registers; the enable and shift outputs are 0.
- **IR latency:** the new `ir` is visible the cycle after UpdIR is exited. `Test_or_Normal` follows one cycle later.
- **Bypass latency:** 1 cycle from TDI to TDO.
- **IR latency, serial:** IR_W cycles from TDI to TDO.

## Test plan
- **Reset state:** Reset=1 for 1 cycle, then TMS=0 → state=C, ir=2'b11, Test_or_Normal=0, all enables 0.
- **TMS-high recovery:** from ShDR, TMS=1 for 5 edges → state=F. Any further TMS=1 stays in F. ir=2'b11.
- **Load EXTEST:** path TLR→RTI→SelDR→SelIR→CapIR→ShIR, shift 2'b00 with TDO showing 1 then 0 (captured 01), then Ex1IR→UpdIR→RTI. Required: ir=00, and Test_or_Normal=1 one cycle later.
- **EXTEST DR scan with 4-cell chain:**
  - BSR_Clock_en high in CapDR and 4 ShDR cycles.
  - Shift_or_Load high only in ShDR.
  - Update high exactly 1 cycle in UpdDR.
- **BYPASS:** shift pattern 1,0,1,1 in ShDR → TDO = 0 (captured), 1, 0, 1. BSR_Clock_en and Update stay 0.
- **Reset mid-ShIR after shifting 2'b00:** Reset=1 → ir remains 2'b11, state=F, and no Update pulse.
